// File: rtl/spectrum_pkg.sv
// Shared types, widths and arithmetic helpers for the dB spectrum normalizer.
// Default widths mirror the top-level parameter defaults.
package spectrum_pkg;

  localparam int DEF_ACCUM_WIDTH = 16;
  localparam int DEF_LOG2_AVG    = 3;
  localparam int DEF_NUM_ACCUMS  = 16;

  localparam int SUM_WIDTH = DEF_ACCUM_WIDTH + DEF_LOG2_AVG;
  localparam int IDX_WIDTH = $clog2(DEF_NUM_ACCUMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_ACCUM,
    S_PEAK,
    S_NORM
  } state_t;

  // a - b saturated to aw-bit signed, then optionally floored at -fl
  function automatic int sat_sub(
    input int a,
    input int b,
    input int aw,
    input int fl,
    input bit clamp_en
  );
    int d;
    int lo;
    int hi;
    d  = a - b;
    lo = -(1 << (aw - 1));
    hi = (1 << (aw - 1)) - 1;
    if (d < lo)
      d = lo;
    else if (d > hi)
      d = hi;
    if (clamp_en && (d < -fl))
      d = -fl;
    return d;
  endfunction

endpackage

// File: rtl/bin_peak_search.sv
// Sequential max search, one bin per cycle.
// Strictly-greater compare keeps the lowest index on ties.
module bin_peak_search
  import spectrum_pkg::*;
#(
  parameter int N  = DEF_NUM_ACCUMS,
  parameter int W  = DEF_ACCUM_WIDTH,
  parameter int IW = IDX_WIDTH
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic signed [W-1:0] val_i [N],
  output logic                done_o,
  output logic [IW-1:0]       idx_o
);

  logic                run;
  logic [IW-1:0]       k;
  logic signed [W-1:0] best_v;
  logic [IW-1:0]       best_i;

  assign done_o = run && (k == IW'(N - 1));
  assign idx_o  = best_i;

  // scan bins 0..N-1, first bin seeds the running maximum
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run    <= 1'b0;
      k      <= '0;
      best_v <= '0;
      best_i <= '0;
    end else if (start_i) begin
      run <= 1'b1;
      k   <= '0;
    end else if (run) begin
      if ((k == '0) || (val_i[k] > best_v)) begin
        best_v <= val_i[k];
        best_i <= k;
      end
      if (k == IW'(N - 1))
        run <= 1'b0;
      k <= k + 1'b1;
    end
  end

endmodule

// File: rtl/spectrum_db_normalizer.sv
// Frame-averaged per-bin dB power, peak search and peak-relative normalization.
// Optional macro DB_FLOOR_CLAMP_EN floors normalized values at -FLOOR_DB.
module spectrum_db_normalizer
  import spectrum_pkg::*;
#(
  parameter int ACCUM_WIDTH    = 16,
  parameter int FREQ_BIN_WIDTH = 9,
  parameter int NUM_ACCUMS     = 16,
  parameter int BIN_START      = 248,
  parameter int LOG2_AVG       = 3,
  parameter int FLOOR_DB       = 60
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             sample_valid_i,
  input  logic signed [ACCUM_WIDTH-1:0]    sample_db_i,
  input  logic [FREQ_BIN_WIDTH-1:0]        sample_bin_i,
  input  logic                             frame_last_i,
  output logic signed [ACCUM_WIDTH-1:0]    accumulator_val_o [NUM_ACCUMS],
  output logic [FREQ_BIN_WIDTH-1:0]        freq_bin_o [NUM_ACCUMS],
  output logic [FREQ_BIN_WIDTH-1:0]        peak_bin_o,
  output logic                             start_o,
  output logic                             valid_o,
  output logic                             busy_o
);

  localparam int SW  = ACCUM_WIDTH + LOG2_AVG;
  localparam int IW  = $clog2(NUM_ACCUMS);
  localparam int CW  = LOG2_AVG + 1;
  localparam int AVG = 1 << LOG2_AVG;

`ifdef DB_FLOOR_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  state_t                        state;
  logic signed [SW-1:0]          sum [NUM_ACCUMS];
  logic signed [ACCUM_WIDTH-1:0] avg [NUM_ACCUMS];
  logic [CW-1:0]                 frame_cnt;
  logic [FREQ_BIN_WIDTH-1:0]     rel;
  logic                          in_win;
  logic [IW-1:0]                 widx;
  logic                          pk_start;
  logic                          pk_done;
  logic [IW-1:0]                 pk_idx;

  for (genvar g = 0; g < NUM_ACCUMS; g++) begin : g_bin
    assign freq_bin_o[g] = FREQ_BIN_WIDTH'(BIN_START + g);
  end

  // window membership and bin offset of the incoming sample
  always_comb begin
    in_win = (int'(sample_bin_i) >= BIN_START) &&
             (int'(sample_bin_i) < BIN_START + NUM_ACCUMS);
    rel    = sample_bin_i - FREQ_BIN_WIDTH'(BIN_START);
    widx   = rel[IW-1:0];
  end

  // floor average of each bin over the frames
  always_comb begin
    for (int k = 0; k < NUM_ACCUMS; k++)
      avg[k] = ACCUM_WIDTH'(sum[k] >>> LOG2_AVG);
  end

  assign pk_start = (state == S_ACCUM) && sample_valid_i &&
                    frame_last_i && (frame_cnt == CW'(AVG - 1));

  bin_peak_search #(
    .N  (NUM_ACCUMS),
    .W  (ACCUM_WIDTH),
    .IW (IW)
  ) u_peak (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (pk_start),
    .val_i   (avg),
    .done_o  (pk_done),
    .idx_o   (pk_idx)
  );

  // measurement FSM with registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      frame_cnt  <= '0;
      peak_bin_o <= '0;
      start_o    <= 1'b0;
      valid_o    <= 1'b0;
      busy_o     <= 1'b0;
      for (int k = 0; k < NUM_ACCUMS; k++) begin
        sum[k]               <= '0;
        accumulator_val_o[k] <= '0;
      end
    end else begin
      start_o <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_i) begin
            for (int k = 0; k < NUM_ACCUMS; k++)
              sum[k] <= '0;
            frame_cnt <= '0;
            valid_o   <= 1'b0;
            busy_o    <= 1'b1;
            state     <= S_ARM;
          end
        end
        S_ARM: begin
          if (sample_valid_i && frame_last_i)
            state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (sample_valid_i) begin
            if (in_win)
              sum[widx] <= sum[widx] + SW'(sample_db_i);
            if (frame_last_i) begin
              frame_cnt <= frame_cnt + 1'b1;
              if (frame_cnt == CW'(AVG - 1))
                state <= S_PEAK;
            end
          end
        end
        S_PEAK: begin
          if (pk_done)
            state <= S_NORM;
        end
        S_NORM: begin
          for (int k = 0; k < NUM_ACCUMS; k++)
            accumulator_val_o[k] <= ACCUM_WIDTH'(sat_sub(
              int'(avg[k]), int'(avg[pk_idx]),
              ACCUM_WIDTH, FLOOR_DB, CLAMP_EN));
          peak_bin_o <= FREQ_BIN_WIDTH'(BIN_START) +
                        FREQ_BIN_WIDTH'(pk_idx);
          valid_o    <= 1'b1;
          start_o    <= 1'b1;
          busy_o     <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spectrum_db_normalizer.sv
// Directed self-checking bench for spectrum_db_normalizer.
// Expected values are hand-computed; DB_FLOOR_CLAMP_EN alters clamp cases.
module tb_spectrum_db_normalizer;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               start_i;
  logic               sample_valid_i;
  logic signed [15:0] sample_db_i;
  logic [8:0]         sample_bin_i;
  logic               frame_last_i;
  logic signed [15:0] accumulator_val_o [16];
  logic [8:0]         freq_bin_o [16];
  logic [8:0]         peak_bin_o;
  logic               start_o;
  logic               valid_o;
  logic               busy_o;

  int n_assert = 0;
  int n_fail   = 0;
  int lat;
  int pulses;
  int exp_deep;
  int exp_sat;
  logic signed [15:0] pat [16];

  spectrum_db_normalizer dut (
    .clk_i             (clk_i),
    .rst_i             (rst_i),
    .start_i           (start_i),
    .sample_valid_i    (sample_valid_i),
    .sample_db_i       (sample_db_i),
    .sample_bin_i      (sample_bin_i),
    .frame_last_i      (frame_last_i),
    .accumulator_val_o (accumulator_val_o),
    .freq_bin_o        (freq_bin_o),
    .peak_bin_o        (peak_bin_o),
    .start_o           (start_o),
    .valid_o           (valid_o),
    .busy_o            (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic put(input int bin, input int db, input bit last);
    sample_valid_i = 1'b1;
    sample_bin_i   = 9'(bin);
    sample_db_i    = 16'(db);
    frame_last_i   = last;
    step();
    sample_valid_i = 1'b0;
    frame_last_i   = 1'b0;
  endtask

  task automatic send_frame(input bit noise);
    for (int k = 0; k < 16; k++) begin
      if (noise && k == 3) begin
        put(247, 100, 1'b0);
        put(264, 100, 1'b0);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
      end
      put(248 + k, int'(pat[k]), k == 15);
    end
  endtask

  task automatic start_arm(input bit junk);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("busy_after_start", int'(busy_o), 1);
    if (junk)
      for (int k = 0; k < 4; k++)
        put(248 + k, 100, k == 3);
    else
      put(300, 0, 1'b1);
  endtask

  task automatic run(input bit junk, input bit noise, output int l);
    start_arm(junk);
    for (int f = 0; f < 8; f++)
      send_frame(noise);
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (start_o === 1'b1) begin
        l = n;
        break;
      end
    end
    chk("start_o_found", int'(l > 0), 1);
    step();
    chk("start_o_one_cycle", int'(start_o), 0);
  endtask

  task automatic check_ramp(input string tag);
    for (int k = 0; k < 16; k++)
      chk(tag, int'(accumulator_val_o[k]), k - 15);
    chk("ramp_peak", int'(peak_bin_o), 263);
    chk("ramp_valid", int'(valid_o), 1);
    chk("ramp_busy", int'(busy_o), 0);
  endtask

  initial begin
`ifdef DB_FLOOR_CLAMP_EN
    exp_deep = -60;
    exp_sat  = -60;
`else
    exp_deep = -30000;
    exp_sat  = -32768;
`endif
    rst_i          = 1'b1;
    start_i        = 1'b0;
    sample_valid_i = 1'b0;
    sample_db_i    = '0;
    sample_bin_i   = '0;
    frame_last_i   = 1'b0;
    step();
    step();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_start", int'(start_o), 0);
    chk("rst_peak", int'(peak_bin_o), 0);
    chk("rst_acc0", int'(accumulator_val_o[0]), 0);
    chk("freq_bin0", int'(freq_bin_o[0]), 248);
    chk("freq_bin15", int'(freq_bin_o[15]), 263);
    rst_i = 1'b0;
    step();

    for (int k = 0; k < 16; k++)
      pat[k] = 16'(-40 + k);
    run(1'b1, 1'b0, lat);
    chk("ramp_latency", lat, 17);
    check_ramp("ramp_acc");

    for (int k = 0; k < 16; k++)
      pat[k] = -16'sd50;
    pat[5] = -16'sd10;
    pat[9] = -16'sd10;
    run(1'b0, 1'b0, lat);
    chk("tie_peak", int'(peak_bin_o), 253);
    chk("tie_acc5", int'(accumulator_val_o[5]), 0);
    chk("tie_acc9", int'(accumulator_val_o[9]), 0);
    chk("tie_acc0", int'(accumulator_val_o[0]), -40);
    chk("tie_acc15", int'(accumulator_val_o[15]), -40);

    for (int k = 0; k < 16; k++)
      pat[k] = -16'sd30000;
    pat[3] = 16'sd0;
    run(1'b0, 1'b0, lat);
    chk("deep_peak", int'(peak_bin_o), 251);
    chk("deep_acc3", int'(accumulator_val_o[3]), 0);
    chk("deep_acc0", int'(accumulator_val_o[0]), exp_deep);

    for (int k = 0; k < 16; k++)
      pat[k] = 16'sd0;
    pat[0] = 16'sd30000;
    pat[1] = -16'sd30000;
    run(1'b0, 1'b0, lat);
    chk("sat_peak", int'(peak_bin_o), 248);
    chk("sat_acc0", int'(accumulator_val_o[0]), 0);
    chk("sat_acc1", int'(accumulator_val_o[1]), exp_sat);
    chk("sat_acc2", int'(accumulator_val_o[2]), exp_deep);

    for (int k = 0; k < 16; k++)
      pat[k] = 16'(-40 + k);
    start_arm(1'b0);
    for (int f = 0; f < 8; f++)
      send_frame(1'b0);
    for (int n = 0; n < 5; n++)
      step();
    chk("peak_busy", int'(busy_o), 1);
    rst_i = 1'b1;
    #1;
    chk("arst_valid", int'(valid_o), 0);
    chk("arst_busy", int'(busy_o), 0);
    chk("arst_peak", int'(peak_bin_o), 0);
    chk("arst_acc1", int'(accumulator_val_o[1]), 0);
    step();
    rst_i = 1'b0;
    pulses = 0;
    for (int n = 0; n < 30; n++) begin
      step();
      if (start_o === 1'b1)
        pulses++;
    end
    chk("arst_no_start", pulses, 0);
    run(1'b0, 1'b0, lat);
    chk("post_rst_latency", lat, 17);
    check_ramp("post_rst_acc");

    run(1'b1, 1'b1, lat);
    chk("noise_latency", lat, 17);
    check_ramp("noise_acc");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/spectrum_db_normalizer.md
# spectrum_db_normalizer

Averages per-bin dB power over 2^LOG2_AVG FFT frames for a NUM_ACCUMS-bin window and locates the peak bin. It then subtracts the peak from every bin, so the peak reads 0 dB and all others read ≤ 0. It sits directly upstream of the bandwidth-edge finders: it drives their accumulator value array, frequency bin array and start pulse.

## Interface
- ACCUM_WIDTH, 16: width of the signed integer-dB input samples and normalized outputs
- FREQ_BIN_WIDTH, 9: FFT bin index width
- NUM_ACCUMS, 16: window size in bins; power of two, ≥ 2
- BIN_START, 248: first FFT bin of the window
- LOG2_AVG, 3: log2 of the number of frames averaged
- FLOOR_DB, 60: positive clamp floor, used only with the floor-clamp macro
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- start_i  in  1  request a measurement; sampled in IDLE only
- sample_valid_i  in  1  input sample strobe; there is no backpressure
- sample_db_i  in  ACCUM_WIDTH  signed dB power of the sample
- sample_bin_i  in  FREQ_BIN_WIDTH  FFT bin index of the sample
- frame_last_i  in  1  qualifies the last sample of a frame; meaningful only with sample_valid_i
- accumulator_val_o[NUM_ACCUMS]  out  ACCUM_WIDTH  normalized signed dB per bin
- freq_bin_o[NUM_ACCUMS]  out  FREQ_BIN_WIDTH  constant BIN_START+k
- peak_bin_o  out  FREQ_BIN_WIDTH  FFT bin index of the peak
- start_o  out  1  one-cycle pulse to the edge finders
- valid_o  out  1  level; outputs hold a completed result
- busy_o  out  1  high in every state except IDLE

## Operation
- States: IDLE → ARM → ACCUM → PEAK → NORM → IDLE.
- IDLE:
  - start_i clears all sums, the frame counter and valid_o, then goes to ARM.
  - start_i in any other state is ignored.
- ARM:
  - Discards samples until an accepted sample with frame_last_i set; that sample is also discarded.
  - Then goes to ACCUM, so averaging always starts on a frame boundary.
- ACCUM:
  - A sample with BIN_START ≤ sample_bin_i < BIN_START+NUM_ACCUMS adds sign-extended sample_db_i into sum[sample_bin_i−BIN_START].
  - Sums are ACCUM_WIDTH+LOG2_AVG bits signed, so they cannot overflow.
  - Out-of-window samples are ignored.
  - A repeated bin within a frame accumulates again.
  - An accepted frame_last_i increments the frame counter. The sample carrying it is accumulated first.
  - When the counter reaches 2^LOG2_AVG, go to PEAK.
- PEAK:
  - avg[k] = sum[k] >>> LOG2_AVG (arithmetic shift, floor).
  - Sequential scan k = 0..NUM_ACCUMS−1, one bin per cycle. A strictly-greater compare keeps the lowest index on ties.
  - After the last bin, go to NORM.
- NORM, one cycle:
  - accumulator_val_o[k] = avg[k] − avg[peak], computed in ACCUM_WIDTH+1 bits and saturated to −2^(ACCUM_WIDTH−1).
  - peak_bin_o = BIN_START + peak index.
  - valid_o is set and start_o pulses.
  - Next state is IDLE.
- In every state other than ACCUM, samples are dropped with no effect.
- Outputs change only in NORM. They stay stable until the next NORM.
- valid_o clears on the next accepted start_i.

## Timing
- Reset values:
  - All accumulator_val_o entries and peak_bin_o are 0.
  - start_o, valid_o and busy_o are 0.
  - State is IDLE; sums and counters are 0.
  - freq_bin_o is constant at all times.
- Reset asserted mid-operation aborts immediately. The block returns to IDLE with the reset values above; no start_o is issued.
- start_i at edge t: busy_o is high from t+1.
- Final frame_last_i accepted at edge t:
  - PEAK occupies t+1 … t+NUM_ACCUMS.
  - NORM is at t+NUM_ACCUMS+1, where start_o, valid_o and the new outputs are all registered.
- start_o is high for exactly one cycle. It coincides with the first cycle the new outputs are visible.
- busy_o is low from the cycle after NORM onward.

## Configuration
- DB_FLOOR_CLAMP_EN defined: any normalized value below −FLOOR_DB is replaced by −FLOOR_DB. This bounds the downstream interpolation operands.
- DB_FLOOR_CLAMP_EN undefined: only the ACCUM_WIDTH saturation applies. FLOOR_DB is unused.

## Structure
- Shared package spectrum_pkg holds:
  - the state enum (IDLE, ARM, ACCUM, PEAK, NORM);
  - the saturating signed-subtract function;
  - the width-derived localparams (SUM_WIDTH, IDX_WIDTH).
- One sub-module, bin_peak_search: sequential max search with lowest-index tie-break. Interface: start, value array, done, index.

## Test plan
- LOG2_AVG=3, bin k constant −40+k every frame (k=0..15), 8 frames after arming:
  - accumulator_val_o[k] = k−15, peak_bin_o = 263.
  - start_o pulses exactly 17 cycles after the last frame_last_i.
- Samples sent before the first frame_last_i after start_i, set to +100 dB: no effect on the result (ARM discard).
- Bins 5 and 9 both at −10, others −50: peak_bin_o = 253; values are 0 at k=5 and 9, −40 elsewhere.
- Bin k = −30000, peak 0:
  - without macro, output −30000;
  - with DB_FLOOR_CLAMP_EN and FLOOR_DB=60, output −60.
  - Separate check: peak 30000, other bin −30000 saturates to −32768.
- rst_i pulsed during PEAK: all outputs return to reset values asynchronously and start_o never pulses. A new start_i then completes normally.
- Out-of-window bins (247, 264) and start_i pulses during ACCUM are ignored: results are identical to a clean run.
